// File: rtl/sd_cmd_tx.sv
// SD command-line serializer with embedded CRC7 generator (x^7 + x^3 + 1).
// Builds the 48-bit command frame and shifts it out MSB-first on sd_tick.
// Optional build macro: SD_CMD_TX_PAD_EN appends PAD_BITS idle '1' bits (Ncc)
// after the end bit before reporting done.

module crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc,
  output logic [6:0] crc_nxt
);

  logic fb;

  // Next CRC value for the current input bit; exported so the caller can use
  // the final value on the same edge it is registered.
  always_comb begin
    fb      = din ^ crc[6];
    crc_nxt = {crc[5], crc[4], crc[3], crc[2] ^ fb, crc[1], crc[0], fb};
  end

  // CRC register: cleared at frame accept, advanced one bit per enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= '0;
    else if (clr)  crc <= '0;
    else if (en)   crc <= crc_nxt;
  end

endmodule

module sd_cmd_tx #(
  parameter int FRAME_BITS = 48,
  parameter int PAD_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_tick,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic [6:0]  crc_out
);

  localparam int DATA_BITS = FRAME_BITS - 8;
  localparam int CRC_BITS  = 7;
  localparam int CNT_MAX   = (PAD_BITS > DATA_BITS) ? PAD_BITS : DATA_BITS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CRC,
    END,
    PAD
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [CRC_BITS-1:0]  crc_sh;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 crc_en;
  logic                 done_n;
  logic [6:0]           crc_reg;
  logic [6:0]           crc_nxt;

  logic data_last;
  logic crc_last;

  assign data_last = (cnt == CNT_W'(DATA_BITS - 1));
  assign crc_last  = (cnt == CNT_W'(CRC_BITS - 1));

  crc7 u_crc7 (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (crc_en),
    .din     (shreg[DATA_BITS-1]),
    .crc     (crc_reg),
    .crc_nxt (crc_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and line outputs; every bit ends on an sd_tick.
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    accept  = 1'b0;
    crc_en  = 1'b0;
    busy    = 1'b1;
    cmd_oe  = 1'b1;
    cmd_out = 1'b1;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        cmd_oe = 1'b0;
        if (start) begin
          accept  = 1'b1;
          state_n = DATA;
        end
      end
      DATA: begin
        cmd_out = shreg[DATA_BITS-1];
        if (sd_tick) begin
          crc_en = 1'b1;
          if (data_last) state_n = CRC;
        end
      end
      CRC: begin
        cmd_out = crc_sh[CRC_BITS-1];
        if (sd_tick && crc_last) state_n = END;
      end
      END: begin
        if (sd_tick) begin
`ifdef SD_CMD_TX_PAD_EN
          state_n = PAD;
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end
      end
`ifdef SD_CMD_TX_PAD_EN
      PAD: begin
        if (sd_tick && (cnt == CNT_W'(PAD_BITS - 1))) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Datapath: frame/CRC shift registers, bit counter, done pulse.
  // The CRC shifter loads the generator's combinational next value on the
  // 40th tick, so the first CRC bit follows the last data bit with no gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      crc_sh  <= '0;
      crc_out <= '0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= done_n;
      if (accept) begin
        shreg <= {1'b0, 1'b1, cmd_index, cmd_arg};
        cnt   <= '0;
      end else if (sd_tick) begin
        case (state)
          DATA: begin
            shreg <= {shreg[DATA_BITS-2:0], 1'b0};
            if (data_last) begin
              cnt     <= '0;
              crc_sh  <= crc_nxt;
              crc_out <= crc_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CRC: begin
            crc_sh <= {crc_sh[CRC_BITS-2:0], 1'b0};
            cnt    <= crc_last ? '0 : cnt + 1'b1;
          end
          END:     cnt <= '0;
          PAD:     cnt <= cnt + 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: scoreboard of expected serial streams,
// captured one bit per sd_tick while the line is driven.

module tb_sd_cmd_tx;

  logic        clk;
  logic        reset;
  logic        sd_tick;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic        cmd_out;
  logic        cmd_oe;
  logic [6:0]  crc_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [63:0] bits;
    int unsigned nbits;
    logic [6:0]  crc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] cap;
  int unsigned nb;
  int unsigned idle_ticks;
  logic        prev_done;

  sd_cmd_tx #(.FRAME_BITS(48), .PAD_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sd_tick   (sd_tick),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .busy      (busy),
    .done      (done),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .crc_out   (crc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sd_tick: one clk high out of every four
  initial begin
    sd_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 sd_tick = 1'b1;
      @(posedge clk);
      #1 sd_tick = 1'b0;
    end
  end

  function automatic void push_exp(input logic [47:0] s);
    exp_t e;
`ifdef SD_CMD_TX_PAD_EN
    e.bits  = {8'h00, s, 8'hFF};
    e.nbits = 56;
`else
    e.bits  = {16'h0000, s};
    e.nbits = 48;
`endif
    e.crc = s[7:1];
    q.push_back(e);
  endfunction

  // Monitor: capture line bits on ticks, score frames on done
  initial begin
    cap = '0; nb = 0; idle_ticks = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cap = '0;
        nb  = 0;
      end else begin
        if (sd_tick && cmd_oe) begin
          cap = {cap[62:0], cmd_out};
          nb++;
        end
        if (sd_tick && !cmd_oe) idle_ticks++;
        if (done) begin
          checks++;
          assert (q.size() != 0) else begin
            errors++; $error("FAIL unexpected_done got done with empty scoreboard want none");
          end
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            assert (nb === e.nbits) else begin
              errors++; $error("FAIL bit_count got %0d want %0d", nb, e.nbits);
            end
            checks++;
            assert (cap === e.bits) else begin
              errors++; $error("FAIL stream got %h want %h", cap, e.bits);
            end
            checks++;
            assert (crc_out === e.crc) else begin
              errors++; $error("FAIL crc_out got %b want %b", crc_out, e.crc);
            end
          end
          checks++;
          assert (prev_done === 1'b0) else begin
            errors++; $error("FAIL done_width got %b prev cycle want 0", prev_done);
          end
          checks++;
          assert (cmd_oe === 1'b0 && cmd_out === 1'b1 && busy === 1'b0) else begin
            errors++; $error("FAIL done_line got oe=%b out=%b busy=%b want 0 1 0", cmd_oe, cmd_out, busy);
          end
          cap = '0;
          nb  = 0;
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++; $error("FAIL idle_timeout got busy=%b want 0", busy);
    end
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++; $error("FAIL done_timeout got done=%b want 1", done);
    end
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg,
                      input logic [47:0] s, input bit expect_frame);
    @(posedge clk); #1;
    wait_idle();
    if (expect_frame) push_exp(s);
    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    assert (busy === 1'b1 && cmd_oe === 1'b1 && cmd_out === 1'b0) else begin
      errors++; $error("FAIL accept got busy=%b oe=%b out=%b want 1 1 0", busy, cmd_oe, cmd_out);
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned idle0;
    bit          saw_done;
    start = 1'b0; cmd_index = '0; cmd_arg = '0;
    reset = 1'b1;
    #2;
    checks++;
    assert (busy === 1'b0 && done === 1'b0 && cmd_out === 1'b1 && cmd_oe === 1'b0 && crc_out === 7'd0) else begin
      errors++; $error("FAIL reset_state got busy=%b done=%b out=%b oe=%b crc=%b want 0 0 1 0 0000000",
                       busy, done, cmd_out, cmd_oe, crc_out);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // CMD0
    send(6'd0, 32'h0000_0000, 48'h400000000095, 1'b1);
    wait_idle();

    // CMD17 with a start pulse mid-frame that must be ignored
    send(6'd17, 32'h0000_0000, 48'h510000000055, 1'b1);
    repeat (30) @(posedge clk);
    #1 cmd_index = 6'd63; cmd_arg = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // CMD8
    send(6'd8, 32'h0000_01AA, 48'h48000001AA87, 1'b1);
    wait_idle();

    // Back-to-back: CMD55 then CMD0 with start held through done
    @(posedge clk); #1;
    idle0 = idle_ticks;
    push_exp(48'h770000000065);
    push_exp(48'h400000000095);
    cmd_index = 6'd55; cmd_arg = '0; start = 1'b1;
    @(posedge clk); #1;
    cmd_index = 6'd0;
    wait_done();
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    assert (busy === 1'b1 && cmd_out === 1'b0) else begin
      errors++; $error("FAIL b2b_accept got busy=%b out=%b want 1 0", busy, cmd_out);
    end
    wait_done();
    checks++;
    assert (idle_ticks === idle0) else begin
      errors++; $error("FAIL b2b_gap got %0d idle ticks want %0d", idle_ticks, idle0);
    end
    wait_idle();

    // Reset after 20 ticks of a frame
    send(6'd8, 32'h0000_01AA, 48'h0, 1'b0);
    n = 0;
    while (nb < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (nb >= 20) else begin
      errors++; $error("FAIL midframe_timeout got %0d bits want 20", nb);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    assert (cmd_oe === 1'b0 && cmd_out === 1'b1 && busy === 1'b0 && done === 1'b0) else begin
      errors++; $error("FAIL async_reset got oe=%b out=%b busy=%b done=%b want 0 1 0 0",
                       cmd_oe, cmd_out, busy, done);
    end
    checks++;
    assert (crc_out === 7'd0) else begin
      errors++; $error("FAIL reset_crc got %b want 0000000", crc_out);
    end
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || cmd_oe) saw_done = 1'b1;
    end
    checks++;
    assert (saw_done === 1'b0) else begin
      errors++; $error("FAIL abort_quiet got done/oe activity want none");
    end

    // Frame after reset still correct
    send(6'd0, 32'h0000_0000, 48'h400000000095, 1'b1);
    wait_idle();
    repeat (4) @(posedge clk);
    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL scoreboard_left got %0d entries want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
